bitplane_serializer: RTL and testbench

- Transmit side of the bit-serial datapath: accepts one parallel vector of VEC_LENGTH signed DATA_WIDTH-bit operands and emits it as DATA_WIDTH bit-planes, one plane per accepted beat, MSB (sign) plane first.
- Sits between the parallel operand register stage and the bit-serial PE array.
- Both sides use valid/ready handshakes; back-to-back vectors stream with no bubble.

---
 rtl/bitplane_serializer.sv | 133 +++++++++++++
 tb/tb_bitplane_serializer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitplane_serializer.sv
// ---------------------------------------------------------------------------
// bitplane_serializer
//
// Transmit side of the bit-serial datapath. A parallel vector of VEC_LENGTH
// signed DATA_WIDTH-bit operands is captured into a shadow register. It is
// then emitted as DATA_WIDTH bit-planes, MSB (sign) plane first, one plane per
// accepted output beat. When the last plane is accepted and a new vector is
// already waiting, that vector is captured in the same cycle. Vectors
// therefore stream back to back without a bubble.
//
// Ports
//   clk        clock
//   reset      synchronous, active-high reset
//   in_valid   a vector is presented on in_data
//   in_ready   the block accepts in_data this cycle (combinational)
//   in_data    operand vector, VEC_LENGTH x signed DATA_WIDTH bits
//   out_valid  out_plane is valid (registered)
//   out_ready  the consumer accepts the current plane
//   out_plane  out_plane[j] = bit out_idx of captured operand j
//   out_idx    bit position of the current plane
//   out_sign   current plane carries the negative (sign) weight
//   out_last   current plane is bit 0, the final plane of the vector
// ---------------------------------------------------------------------------
module bitplane_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LENGTH = 8,
    parameter int IDX_W      = $clog2(DATA_WIDTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data [VEC_LENGTH-1:0],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [VEC_LENGTH-1:0]        out_plane,
    output logic [IDX_W-1:0]             out_idx,
    output logic                         out_sign,
    output logic                         out_last
);

    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    typedef enum logic {
        IDLE = 1'b0,   // nothing buffered
        SEND = 1'b1    // shadow holds a vector, planes are being emitted
    } state_t;

    state_t                         state;
    logic signed [DATA_WIDTH-1:0]   shadow [VEC_LENGTH-1:0];
    logic                           in_accept;
    logic                           out_accept;

    // A new vector may enter when the block is empty. It may also enter on
    // the cycle the final plane leaves, which keeps vectors bubble-free.
    assign in_ready   = !reset && ((state == IDLE) ||
                                   (state == SEND && out_last && out_ready));
    assign in_accept  = in_valid && in_ready;
    assign out_accept = out_valid && out_ready;

    // The plane is a pure select of registered state (shadow, out_idx).
    // It therefore holds while the consumer stalls.
    // NOTE: every signal driven in always_comb gets a default before any
    // conditional or loop assignment, so no path can infer a latch.
    always_comb begin
        out_plane = '0;
        for (int j = 0; j < VEC_LENGTH; j++) begin
            out_plane[j] = shadow[j][out_idx];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then updates from values sampled before the edge, and
    // simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_idx   <= IDX_MSB;
            out_sign  <= 1'b1;
            out_last  <= 1'b0;
            // NOTE: the shadow register is cleared on reset, even though it is
            // only read while out_valid=1. That gives out_plane a defined zero
            // value after reset instead of leftover data from a previous run.
            shadow    <= '{default: '0};
        end else begin
            case (state)
                IDLE: begin
                    if (in_accept) begin
                        state     <= SEND;
                        out_valid <= 1'b1;
                        shadow    <= in_data;
                        out_idx   <= IDX_MSB;
                        out_sign  <= 1'b1;
                        out_last  <= 1'b0;
                    end
                end

                SEND: begin
                    // Without an output accept nothing changes, so the plane,
                    // the index and the flags stay stable under backpressure.
                    if (out_accept) begin
                        if (out_last) begin
                            // The next plane restarts at the sign bit, either
                            // for a freshly captured vector or for the idle
                            // state.
                            out_idx  <= IDX_MSB;
                            out_sign <= 1'b1;
                            out_last <= 1'b0;
                            if (in_accept) begin
                                shadow <= in_data;
                            end else begin
                                state     <= IDLE;
                                out_valid <= 1'b0;
                            end
                        end else begin
                            out_idx  <= out_idx - IDX_ONE;
                            out_sign <= 1'b0;
                            out_last <= (out_idx == IDX_ONE);
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitplane_serializer.sv
// ---------------------------------------------------------------------------
// tb_bitplane_serializer
//
// Directed bench for bitplane_serializer with DATA_WIDTH = VEC_LENGTH = 8.
// Inputs are driven on the falling clock edge. Outputs are sampled on the
// falling edge, or 1 ns after an input change for the combinational in_ready.
// Expected planes are hand-derived from the operand bit patterns.
// ---------------------------------------------------------------------------
module tb_bitplane_serializer;

    localparam int DW = 8;
    localparam int VL = 8;
    localparam int IW = 3;

    logic                 clk;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data [VL-1:0];
    logic                 out_valid;
    logic                 out_ready;
    logic [VL-1:0]        out_plane;
    logic [IW-1:0]        out_idx;
    logic                 out_sign;
    logic                 out_last;

    int errors = 0;
    int checks = 0;

    bitplane_serializer #(
        .DATA_WIDTH (DW),
        .VEC_LENGTH (VL),
        .IDX_W      (IW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_plane (out_plane),
        .out_idx   (out_idx),
        .out_sign  (out_sign),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed beat: {valid, idx, sign, last, plane}
    function automatic logic [13:0] obs();
        return {out_valid, out_idx, out_sign, out_last, out_plane};
    endfunction

    // Expected beat for a valid plane at bit position k
    function automatic logic [13:0] beat(input int k, input logic [7:0] plane);
        return {1'b1, 3'(k), (k == 7), (k == 0), plane};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_all(input logic [7:0] v);
        for (int j = 0; j < VL; j++) in_data[j] = v;
    endtask

    task automatic set_random();
        for (int j = 0; j < VL; j++) in_data[j] = 8'($urandom);
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        set_all(8'h5A);
        tick();
        tick();
        #1;
        checks++;
        if ({out_valid, out_idx, out_sign, out_last, out_plane} !== {1'b0, 3'd7, 1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs(), {1'b0, 3'd7, 1'b1, 1'b0, 8'h00});
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        tick();
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_in_ready: got %b expected 1", in_ready);
        end
        tick();
    endtask

    // ---------------------------------------------------------------------
    // Operand 0 = 0x81 (bits 7 and 0 set), all others zero.
    task automatic test_basic();
        set_all(8'h00);
        in_data[0] = 8'sh81;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_no_early_beat: got valid=%b expected 0", out_valid);
        end
        tick();
        in_valid = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            logic [7:0] exp_plane;
            exp_plane = (k == 7 || k == 0) ? 8'h01 : 8'h00;
            checks++;
            if (obs() !== beat(k, exp_plane)) begin
                errors++;
                $display("FAIL basic_beat idx%0d: got %h expected %h", k, obs(), beat(k, exp_plane));
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_end: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
        end
    endtask

    // ---------------------------------------------------------------------
    // All -1 (every plane 0xFF), then 0x40 x8 captured on the last beat.
    task automatic test_back_to_back();
        logic [7:0] exp2 [8];
        exp2 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00}; // idx 0..7
        set_all(8'hFF);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            checks++;
            if (obs() !== beat(k, 8'hFF)) begin
                errors++;
                $display("FAIL b2b_first idx%0d: got %h expected %h", k, obs(), beat(k, 8'hFF));
            end
            if (k == 0) begin
                set_all(8'h40);
                in_valid = 1'b1;
                #1;
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_last_in_ready: got %b expected 1", in_ready);
                end
            end else begin
                #1;
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_mid_in_ready idx%0d: got %b expected 0", k, in_ready);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        set_all(8'h00);
        for (int k = 7; k >= 0; k--) begin
            checks++;
            if (obs() !== beat(k, exp2[k])) begin
                errors++;
                $display("FAIL b2b_second idx%0d: got %h expected %h", k, obs(), beat(k, exp2[k]));
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got valid=%b expected 0", out_valid);
        end
    endtask

    // ---------------------------------------------------------------------
    // Operand 0 = 0x10 (bit 4 only). Stall 3 cycles at idx 4, with a new
    // vector offered during the stall that must not be taken.
    task automatic test_backpressure();
        set_all(8'h00);
        in_data[0] = 8'sh10;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_all(8'hFF);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (obs() !== beat(4, 8'h01)) begin
                errors++;
                $display("FAIL stall_hold cycle%0d: got %h expected %h", c, obs(), beat(4, 8'h01));
            end
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_in_ready cycle%0d: got %b expected 0", c, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int k = 4; k >= 0; k--) begin
            logic [7:0] exp_plane;
            exp_plane = (k == 4) ? 8'h01 : 8'h00;
            checks++;
            if (obs() !== beat(k, exp_plane)) begin
                errors++;
                $display("FAIL stall_resume idx%0d: got %h expected %h", k, obs(), beat(k, exp_plane));
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_end: got valid=%b expected 0", out_valid);
        end
    endtask

    // ---------------------------------------------------------------------
    // Even operands 0xA5, odd operands 0x3C. in_data is scrambled every
    // cycle afterwards, with in_valid high on the middle beats.
    task automatic test_data_change();
        logic [7:0] exp [8];
        exp = '{8'h55, 8'h00, 8'hFF, 8'hAA, 8'hAA, 8'hFF, 8'h00, 8'h55}; // idx 0..7
        for (int j = 0; j < VL; j++) in_data[j] = (j % 2 == 0) ? 8'shA5 : 8'sh3C;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        for (int k = 7; k >= 0; k--) begin
            set_random();
            in_valid = (k != 0);
            checks++;
            if (obs() !== beat(k, exp[k])) begin
                errors++;
                $display("FAIL data_change idx%0d: got %h expected %h", k, obs(), beat(k, exp[k]));
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL data_change_end: got valid=%b expected 0", out_valid);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reset at idx 3, then 0x7F x8: plane 0x00 at idx 7, 0xFF below.
    task automatic test_reset_mid();
        set_all(8'h55);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        checks++;
        if (out_idx !== 3'd3 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: got idx=%0d valid=%b expected idx=3 valid=1", out_idx, out_valid);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_in_ready_during: got %b expected 0", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_idx !== 3'd7) begin
            errors++;
            $display("FAIL rstmid_after: got valid=%b idx=%0d expected valid=0 idx=7", out_valid, out_idx);
        end
        reset = 1'b0;
        set_all(8'h7F);
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in_ready_release: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            logic [7:0] exp_plane;
            exp_plane = (k == 7) ? 8'h00 : 8'hFF;
            checks++;
            if (obs() !== beat(k, exp_plane)) begin
                errors++;
                $display("FAIL rstmid_vec idx%0d: got %h expected %h", k, obs(), beat(k, exp_plane));
            end
            tick();
        end
    endtask

    // ---------------------------------------------------------------------
    // Drain to idle, wait, then a single in_valid pulse with 0x01 x8.
    task automatic test_idle_return();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_state: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
        end
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got valid=%b expected 0", out_valid);
        end
        set_all(8'h01);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_pulse_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            logic [7:0] exp_plane;
            exp_plane = (k == 0) ? 8'hFF : 8'h00;
            checks++;
            if (obs() !== beat(k, exp_plane)) begin
                errors++;
                $display("FAIL idle_pulse_vec idx%0d: got %h expected %h", k, obs(), beat(k, exp_plane));
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_pulse_end: got valid=%b expected 0", out_valid);
        end
    endtask

    // ---------------------------------------------------------------------
    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_all(8'h00);
        tick();
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_data_change();
        test_reset_mid();
        test_idle_return();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
